mc_ctrl_fsm: RTL and testbench
==============================

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 The block SHALL have these parameters:
- MEM_TIMEOUT, default 16: maximum cycles to wait for imemReady/dmemAck; 0 means wait forever.
- TRAP_HALT, default 1: 1 means stay in TRAP until reset; 0 means skip the faulting instruction and resume.
REQ-002 The block SHALL have these ports, one clock domain, reset asynchronous and active-low:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- instrCode  in  32  current instruction-register contents
- imemReady  in  1  instruction memory data valid
- dmemAck  in  1  data memory access complete
- pcEn  out  1  PC update strobe
- irEn  out  1  instruction-register load strobe
- imemReq  out  1  instruction fetch request
- dmemReq  out  1  data memory request
- regFileWe  out  1  register file write enable
- aluSrcMuxSel  out  1  ALU B source: 1 = immediate
- dataWe  out  1  data memory write enable
- RFWDSrcMuxSel  out  3  writeback source: 000 ALU, 001 load, 010 LUI, 011 AUIPC, 100 PC+4
- branch, jal, jalr  out  1 each  next-PC selects
- aluControl  out  4  ALU operation
- trap  out  1  one-cycle pulse on trap entry
- trapCause  out  2  01 illegal opcode, 10 memory timeout; holds last cause
- halted  out  1  high while parked in TRAP (TRAP_HALT=1)

Function
REQ-003 The block SHALL implement the states FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB, TRAP.
REQ-004 The decoded fields SHALL be:
- opcode = instrCode[6:0]
- operators = {instrCode[30], instrCode[14:12]}
REQ-005 In FETCH, the block SHALL assert imemReq and hold it until imemReady=1. In the imemReady cycle it SHALL pulse irEn and go to DECODE.
REQ-006 DECODE SHALL dispatch on opcode to the matching EXE state:
- 0110011 R, 0010011 I, 1100011 B, 0110111 LU, 0010111 AU
- 1101111 J, 1100111 JL, 0100011 S, 0000011 L
- any other opcode goes to TRAP with trapCause=01
REQ-007 R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE and JL_EXE SHALL each last one cycle, assert pcEn, and go to FETCH.
REQ-008 Stores SHALL run S_EXE then S_MEM. S_MEM SHALL hold dmemReq=1 and dataWe=1 until dmemAck, then assert pcEn in the ack cycle and go to FETCH.
REQ-009 Loads SHALL run L_EXE then L_MEM then L_WB. L_MEM SHALL hold dmemReq=1 until dmemAck. L_WB SHALL assert regFileWe=1 and pcEn=1 and go to FETCH.
REQ-010 Outputs per state SHALL be (all unlisted outputs are 0):
- R_EXE: regFileWe
- I_EXE: regFileWe, aluSrcMuxSel
- B_EXE: branch
- LU_EXE: regFileWe, RFWDSrcMuxSel=010
- AU_EXE: regFileWe, RFWDSrcMuxSel=011
- J_EXE: regFileWe, jal, RFWDSrcMuxSel=100
- JL_EXE: regFileWe, jal, jalr, RFWDSrcMuxSel=100
- S_EXE, S_MEM: aluSrcMuxSel
- L_EXE, L_MEM, L_WB: aluSrcMuxSel, RFWDSrcMuxSel=001
REQ-011 aluControl SHALL default to operators, with these overrides:
- S_EXE, L_EXE, JL_EXE: 0000 (ADD)
- I_EXE: operators when operators==1101, else {1'b0, instrCode[14:12]}
REQ-012 A wait counter SHALL clear on entry to FETCH, S_MEM and L_MEM and increment each cycle the handshake input is low.
REQ-013 When MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with the handshake input still low, the block SHALL go to TRAP with trapCause=10 and drop all requests.
REQ-014 Counter width SHALL be $clog2(MEM_TIMEOUT+1), minimum 1 bit.
REQ-015 A handshake arriving in the same cycle the timeout is reached SHALL count as success, not trap.
REQ-016 trap SHALL pulse for exactly the first cycle in TRAP.
REQ-017 With TRAP_HALT=1, TRAP SHALL be terminal: halted=1, all strobes 0, exit only by reset.
REQ-018 With TRAP_HALT=0, TRAP SHALL last one cycle with pcEn=1, then go to FETCH; halted SHALL stay 0.
REQ-019 All outputs SHALL be decoded from the registered state and instrCode only, with no combinational path from imemReady/dmemAck to next-state except the handshake qualifiers.

Reset
REQ-020 While reset_n=0, the state SHALL be FETCH, the counter 0, trapCause 00, and trap/halted 0.
REQ-021 Reset asserted mid-instruction, including during S_MEM with dataWe=1, SHALL deassert all strobes asynchronously.
REQ-022 The first cycle after release SHALL be FETCH with imemReq=1.

Verification
REQ-023 ADD (0x002081B3) with imemReady=1 immediately SHALL give FETCH, DECODE, R_EXE. R_EXE SHALL show regFileWe=1, pcEn=1, aluControl=0000, for a total of 3 cycles.
REQ-024 SW with dmemAck after 3 cycles SHALL hold S_MEM with dataWe=1 and dmemReq=1 for 4 cycles. pcEn SHALL be 1 only in the ack cycle.
REQ-025 LW with immediate ack SHALL take 5 cycles. L_WB SHALL show regFileWe=1 and RFWDSrcMuxSel=001.
REQ-026 Opcode 0x7F with TRAP_HALT=1 SHALL pulse trap for 1 cycle with trapCause=01, then hold halted=1 for 20+ cycles. With TRAP_HALT=0 it SHALL give pcEn=1 then FETCH.
REQ-027 With MEM_TIMEOUT=4 and dmemAck never asserted during a load, the block SHALL enter TRAP with trapCause=10 after 4 cycles in L_MEM. An ack on cycle 4 SHALL proceed to L_WB.
REQ-028 Asserting reset_n=0 in S_MEM SHALL drop dataWe the same cycle. After release the block SHALL be in FETCH with imemReq=1.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle RV32I control sequencer.
// Fetch/decode/execute with memory handshake timeout and trap handling.
module mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter bit TRAP_HALT   = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instrCode,
  input  logic        imemReady,
  input  logic        dmemAck,
  output logic        pcEn,
  output logic        irEn,
  output logic        imemReq,
  output logic        dmemReq,
  output logic        regFileWe,
  output logic        aluSrcMuxSel,
  output logic        dataWe,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic [3:0]  aluControl,
  output logic        trap,
  output logic [1:0]  trapCause,
  output logic        halted
);

  localparam int CW =
    (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int LAST_I =
    (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

  typedef enum logic [3:0] {
    FETCH, DECODE, R_EXE, I_EXE, B_EXE,
    LU_EXE, AU_EXE, J_EXE, JL_EXE,
    S_EXE, S_MEM, L_EXE, L_MEM, L_WB, TRAP
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      cause;
  logic            trap_q;
  logic [6:0]      opcode;
  logic [3:0]      ops;
  logic            tmo;
  logic            unused_bits;

  assign opcode = instrCode[6:0];
  assign ops    = {instrCode[30], instrCode[14:12]};
  assign unused_bits =
    ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  // Timeout fires on the last allowed wait cycle; a handshake wins.
  assign tmo = (MEM_TIMEOUT > 0) && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= FETCH;
      cnt    <= '0;
      cause  <= 2'b00;
      trap_q <= 1'b0;
    end else begin
      trap_q <= 1'b0;
      cnt    <= '0;
      unique case (state)
        FETCH:
          if (imemReady) state <= DECODE;
          else if (tmo) begin
            state  <= TRAP;
            cause  <= 2'b10;
            trap_q <= 1'b1;
          end else cnt <= cnt + CW'(1);
        DECODE:
          unique case (opcode)
            7'b0110011: state <= R_EXE;
            7'b0010011: state <= I_EXE;
            7'b1100011: state <= B_EXE;
            7'b0110111: state <= LU_EXE;
            7'b0010111: state <= AU_EXE;
            7'b1101111: state <= J_EXE;
            7'b1100111: state <= JL_EXE;
            7'b0100011: state <= S_EXE;
            7'b0000011: state <= L_EXE;
            default: begin
              state  <= TRAP;
              cause  <= 2'b01;
              trap_q <= 1'b1;
            end
          endcase
        S_EXE: state <= S_MEM;
        S_MEM:
          if (dmemAck) state <= FETCH;
          else if (tmo) begin
            state  <= TRAP;
            cause  <= 2'b10;
            trap_q <= 1'b1;
          end else cnt <= cnt + CW'(1);
        L_EXE: state <= L_MEM;
        L_MEM:
          if (dmemAck) state <= L_WB;
          else if (tmo) begin
            state  <= TRAP;
            cause  <= 2'b10;
            trap_q <= 1'b1;
          end else cnt <= cnt + CW'(1);
        TRAP:
          if (!TRAP_HALT) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    pcEn          = 1'b0;
    irEn          = 1'b0;
    imemReq       = 1'b0;
    dmemReq       = 1'b0;
    regFileWe     = 1'b0;
    aluSrcMuxSel  = 1'b0;
    dataWe        = 1'b0;
    RFWDSrcMuxSel = 3'b000;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    aluControl    = ops;
    unique case (state)
      FETCH: begin
        imemReq = 1'b1;
        irEn    = imemReady;
      end
      R_EXE: begin
        regFileWe = 1'b1;
        pcEn      = 1'b1;
      end
      I_EXE: begin
        regFileWe    = 1'b1;
        aluSrcMuxSel = 1'b1;
        pcEn         = 1'b1;
        aluControl   = (ops == 4'b1101) ? ops
                     : {1'b0, instrCode[14:12]};
      end
      B_EXE: begin
        branch = 1'b1;
        pcEn   = 1'b1;
      end
      LU_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = 3'b010;
        pcEn          = 1'b1;
      end
      AU_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = 3'b011;
        pcEn          = 1'b1;
      end
      J_EXE: begin
        regFileWe     = 1'b1;
        jal           = 1'b1;
        RFWDSrcMuxSel = 3'b100;
        pcEn          = 1'b1;
      end
      JL_EXE: begin
        regFileWe     = 1'b1;
        jal           = 1'b1;
        jalr          = 1'b1;
        RFWDSrcMuxSel = 3'b100;
        pcEn          = 1'b1;
        aluControl    = 4'b0000;
      end
      S_EXE: begin
        aluSrcMuxSel = 1'b1;
        aluControl   = 4'b0000;
      end
      S_MEM: begin
        aluSrcMuxSel = 1'b1;
        dmemReq      = 1'b1;
        dataWe       = 1'b1;
        pcEn         = dmemAck;
      end
      L_EXE: begin
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = 3'b001;
        aluControl    = 4'b0000;
      end
      L_MEM: begin
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = 3'b001;
        dmemReq       = 1'b1;
      end
      L_WB: begin
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = 3'b001;
        regFileWe     = 1'b1;
        pcEn          = 1'b1;
      end
      TRAP: pcEn = !TRAP_HALT;
      default: ;
    endcase
    // Strobes must fall with reset even mid-cycle.
    if (!reset_n) begin
      pcEn      = 1'b0;
      irEn      = 1'b0;
      imemReq   = 1'b0;
      dmemReq   = 1'b0;
      regFileWe = 1'b0;
      dataWe    = 1'b0;
    end
  end

  assign trap      = trap_q;
  assign trapCause = cause;
  assign halted    = TRAP_HALT && (state == TRAP);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: vector table, corner sequences and random
// instruction stream against a cycle-count reference model.
module tb_mc_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] instr [2];
  logic        rdy [2];
  logic        ack [2];
  logic        pcEn [2];
  logic        irEn [2];
  logic        imemReq [2];
  logic        dmemReq [2];
  logic        regFileWe [2];
  logic        aluSrc [2];
  logic        dataWe [2];
  logic [2:0]  wd [2];
  logic        br [2];
  logic        jal [2];
  logic        jalr [2];
  logic [3:0]  alu [2];
  logic        trap [2];
  logic [1:0]  cause [2];
  logic        halted [2];

  mc_ctrl_fsm #(.MEM_TIMEOUT(4), .TRAP_HALT(1'b1)) dut_a (
    .clk(clk), .reset_n(rst_n), .instrCode(instr[0]),
    .imemReady(rdy[0]), .dmemAck(ack[0]),
    .pcEn(pcEn[0]), .irEn(irEn[0]), .imemReq(imemReq[0]),
    .dmemReq(dmemReq[0]), .regFileWe(regFileWe[0]),
    .aluSrcMuxSel(aluSrc[0]), .dataWe(dataWe[0]),
    .RFWDSrcMuxSel(wd[0]), .branch(br[0]), .jal(jal[0]),
    .jalr(jalr[0]), .aluControl(alu[0]), .trap(trap[0]),
    .trapCause(cause[0]), .halted(halted[0])
  );

  mc_ctrl_fsm #(.MEM_TIMEOUT(4), .TRAP_HALT(1'b0)) dut_b (
    .clk(clk), .reset_n(rst_n), .instrCode(instr[1]),
    .imemReady(rdy[1]), .dmemAck(ack[1]),
    .pcEn(pcEn[1]), .irEn(irEn[1]), .imemReq(imemReq[1]),
    .dmemReq(dmemReq[1]), .regFileWe(regFileWe[1]),
    .aluSrcMuxSel(aluSrc[1]), .dataWe(dataWe[1]),
    .RFWDSrcMuxSel(wd[1]), .branch(br[1]), .jal(jal[1]),
    .jalr(jalr[1]), .aluControl(alu[1]), .trap(trap[1]),
    .trapCause(cause[1]), .halted(halted[1])
  );

  int tests = 0;
  int fails = 0;
  int icnt [2];
  int dcnt [2];
  int rdly [2];
  int adly [2];

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  alu;
    logic        we, src;
    logic [2:0]  wd;
    logic        br, jal, jalr, pc;
    int          len;
  } vec_t;

  vec_t tv [12];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Memory responders: answer after rdly/adly waiting cycles.
  task automatic set_in(input int d);
    rdy[d] = imemReq[d] && (icnt[d] >= rdly[d]);
    ack[d] = dmemReq[d] && (dcnt[d] >= adly[d]);
  endtask

  task automatic cyc(input int d);
    icnt[d] = imemReq[d] ? icnt[d] + 1 : 0;
    dcnt[d] = dmemReq[d] ? dcnt[d] + 1 : 0;
    @(posedge clk);
    #1;
    set_in(d);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rdy[d] = 1'b0;
      ack[d] = 1'b0;
      icnt[d] = 0;
      dcnt[d] = 0;
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("reset_state%0d", d),
          32'({pcEn[d], irEn[d], dmemReq[d], regFileWe[d],
               dataWe[d], trap[d], halted[d], cause[d]}),
          32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_in(0);
    set_in(1);
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("post_reset_fetch%0d", d),
          32'(imemReq[d]), 32'd1);
  endtask

  task automatic start(input int d, input logic [31:0] ins);
    instr[d] = ins;
    set_in(d);
    #1;
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h63, 7'h37, 7'h17,
                      7'h6F, 7'h67, 7'h23, 7'h03};
  endfunction

  task automatic hold_halt(input int n);
    int good;
    good = 0;
    for (int j = 0; j < n; j++) begin
      cyc(0);
      if (halted[0] && !trap[0] && !pcEn[0] && !irEn[0] &&
          !imemReq[0] && !dmemReq[0] && !regFileWe[0] &&
          !dataWe[0])
        good++;
    end
    chk("halt_hold", 32'(good), 32'(n));
  endtask

  logic [6:0] opc [9];

  initial begin
    rst_n = 1'b0;
    instr[0] = 32'h13;
    instr[1] = 32'h13;
    rdly[0] = 0; rdly[1] = 0;
    adly[0] = 0; adly[1] = 0;
    opc = '{7'h33, 7'h13, 7'h63, 7'h37, 7'h17,
            7'h6F, 7'h67, 7'h23, 7'h03};

    tv[0]  = '{32'h002081B3, 4'h0, 1'b1, 1'b0, 3'b000,
               1'b0, 1'b0, 1'b0, 1'b1, 3};
    tv[1]  = '{32'h402081B3, 4'h8, 1'b1, 1'b0, 3'b000,
               1'b0, 1'b0, 1'b0, 1'b1, 3};
    tv[2]  = '{32'h4030D093, 4'hD, 1'b1, 1'b1, 3'b000,
               1'b0, 1'b0, 1'b0, 1'b1, 3};
    tv[3]  = '{32'hC0008093, 4'h0, 1'b1, 1'b1, 3'b000,
               1'b0, 1'b0, 1'b0, 1'b1, 3};
    tv[4]  = '{32'h0040C093, 4'h4, 1'b1, 1'b1, 3'b000,
               1'b0, 1'b0, 1'b0, 1'b1, 3};
    tv[5]  = '{32'h00209463, 4'h1, 1'b0, 1'b0, 3'b000,
               1'b1, 1'b0, 1'b0, 1'b1, 3};
    tv[6]  = '{32'h123450B7, 4'h5, 1'b1, 1'b0, 3'b010,
               1'b0, 1'b0, 1'b0, 1'b1, 3};
    tv[7]  = '{32'h00001097, 4'h1, 1'b1, 1'b0, 3'b011,
               1'b0, 1'b0, 1'b0, 1'b1, 3};
    tv[8]  = '{32'h008000EF, 4'h0, 1'b1, 1'b0, 3'b100,
               1'b0, 1'b1, 1'b0, 1'b1, 3};
    tv[9]  = '{32'h400080E7, 4'h0, 1'b1, 1'b0, 3'b100,
               1'b0, 1'b1, 1'b1, 1'b1, 3};
    tv[10] = '{32'h0020A023, 4'h0, 1'b0, 1'b1, 3'b000,
               1'b0, 1'b0, 1'b0, 1'b0, 4};
    tv[11] = '{32'h0000A083, 4'h0, 1'b0, 1'b1, 3'b001,
               1'b0, 1'b0, 1'b0, 1'b0, 5};

    // Table: back-to-back instructions, zero-wait memory.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      int npc;
      logic lastpc;
      npc = 0;
      lastpc = 1'b0;
      start(0, tv[i].ins);
      for (int k = 0; k < tv[i].len; k++) begin
        if (k > 0) cyc(0);
        if (k == 2)
          chk($sformatf("exe_outs[%0d]", i),
              32'({alu[0], regFileWe[0], aluSrc[0], wd[0],
                   br[0], jal[0], jalr[0], pcEn[0]}),
              32'({tv[i].alu, tv[i].we, tv[i].src, tv[i].wd,
                   tv[i].br, tv[i].jal, tv[i].jalr,
                   tv[i].pc}));
        npc += int'(pcEn[0]);
        if (k == tv[i].len - 1) lastpc = pcEn[0];
      end
      chk($sformatf("len_pc[%0d]", i),
          32'({npc[3:0], lastpc}), 32'({4'd1, 1'b1}));
      cyc(0);
    end

    // SW with ack on the 4th S_MEM cycle.
    rdly[0] = 0;
    adly[0] = 3;
    do_reset();
    start(0, 32'h0020A023);
    cyc(0);
    cyc(0);
    for (int k = 3; k < 7; k++) begin
      cyc(0);
      chk($sformatf("sw_mem_c%0d", k),
          32'({dataWe[0], dmemReq[0], pcEn[0]}),
          32'({1'b1, 1'b1, k == 6}));
    end
    cyc(0);
    chk("sw_after", 32'({imemReq[0], dataWe[0]}), 32'b10);

    // LW with ack on the timeout cycle proceeds to writeback.
    do_reset();
    start(0, 32'h0000A083);
    cyc(0);
    cyc(0);
    for (int k = 3; k < 7; k++) begin
      cyc(0);
      chk($sformatf("lw_mem_c%0d", k),
          32'({dmemReq[0], regFileWe[0], trap[0]}), 32'b100);
    end
    cyc(0);
    chk("lw_wb",
        32'({regFileWe[0], pcEn[0], wd[0], trap[0]}),
        32'({1'b1, 1'b1, 3'b001, 1'b0}));

    // LW timeout: trap with cause 10 after 4 L_MEM cycles.
    adly[0] = 100;
    do_reset();
    start(0, 32'h0000A083);
    for (int k = 1; k < 7; k++) cyc(0);
    chk("lw_tmo_last", 32'(dmemReq[0]), 32'd1);
    cyc(0);
    chk("lw_tmo_trap",
        32'({trap[0], cause[0], halted[0], dmemReq[0], pcEn[0]}),
        32'({1'b1, 2'b10, 1'b1, 1'b0, 1'b0}));
    hold_halt(22);

    // Illegal opcode, halting variant.
    adly[0] = 0;
    do_reset();
    start(0, 32'h0000007F);
    cyc(0);
    cyc(0);
    chk("ill_trap_a",
        32'({trap[0], cause[0], halted[0], pcEn[0]}),
        32'({1'b1, 2'b01, 1'b1, 1'b0}));
    hold_halt(21);

    // Illegal opcode, resuming variant.
    do_reset();
    start(1, 32'h0000007F);
    cyc(1);
    cyc(1);
    chk("ill_trap_b",
        32'({trap[1], cause[1], halted[1], pcEn[1]}),
        32'({1'b1, 2'b01, 1'b0, 1'b1}));
    cyc(1);
    chk("ill_resume_b",
        32'({imemReq[1], trap[1], halted[1], cause[1]}),
        32'({1'b1, 1'b0, 1'b0, 2'b01}));

    // Fetch timeout.
    rdly[0] = 100;
    do_reset();
    start(0, 32'h002081B3);
    for (int k = 1; k < 4; k++) cyc(0);
    chk("if_tmo_last", 32'({imemReq[0], trap[0]}), 32'b10);
    cyc(0);
    chk("if_tmo_trap",
        32'({trap[0], cause[0], imemReq[0]}),
        32'({1'b1, 2'b10, 1'b0}));

    // Asynchronous reset in the middle of S_MEM.
    rdly[0] = 0;
    adly[0] = 100;
    do_reset();
    start(0, 32'h0020A023);
    for (int k = 1; k < 5; k++) cyc(0);
    chk("smem_we", 32'({dataWe[0], dmemReq[0]}), 32'b11);
    rst_n = 1'b0;
    #1;
    chk("smem_async_rst",
        32'({dataWe[0], dmemReq[0], pcEn[0], regFileWe[0]}),
        32'd0);
    adly[0] = 0;
    do_reset();

    // Random stream on the resuming variant vs cycle-count model.
    begin
      logic [1:0] last_cause;
      last_cause = 2'b00;
      rdly[1] = 0;
      adly[1] = 0;
      do_reset();
      for (int n = 0; n < 80; n++) begin
        int c, rd, ad, f, len;
        int e_ireq, e_iren, e_dreq, e_dwe, e_rfwe, e_pc, e_trap;
        int a_ireq, a_iren, a_dreq, a_dwe, a_rfwe, a_pc, a_trap;
        int a_halt;
        logic [6:0] op;
        c  = $urandom_range(0, 9);
        rd = ($urandom_range(0, 9) == 0) ? 4 + $urandom_range(0, 2)
                                         : $urandom_range(0, 3);
        ad = ($urandom_range(0, 5) == 0) ? 4 + $urandom_range(0, 2)
                                         : $urandom_range(0, 3);
        if (c < 9) op = opc[c];
        else begin
          op = 7'($urandom_range(0, 127));
          while (is_legal(op)) op = 7'($urandom_range(0, 127));
        end
        e_ireq = 0; e_iren = 0; e_dreq = 0; e_dwe = 0;
        e_rfwe = 0; e_pc = 1; e_trap = 0;
        if (rd >= 4) begin
          len = 5; e_ireq = 4; e_trap = 1; last_cause = 2'b10;
        end else begin
          f = rd + 1;
          e_ireq = f;
          e_iren = 1;
          if (c == 9) begin
            len = f + 2; e_trap = 1; last_cause = 2'b01;
          end else if (c < 7) begin
            len = f + 2;
            e_rfwe = (c != 2) ? 1 : 0;
          end else if (ad >= 4) begin
            len = f + 2 + 4 + 1;
            e_dreq = 4;
            e_dwe = (c == 7) ? 4 : 0;
            e_trap = 1;
            last_cause = 2'b10;
          end else if (c == 7) begin
            len = f + 2 + ad + 1;
            e_dreq = ad + 1;
            e_dwe = ad + 1;
          end else begin
            len = f + 2 + ad + 2;
            e_dreq = ad + 1;
            e_rfwe = 1;
          end
        end
        rdly[1] = rd;
        adly[1] = ad;
        start(1, ($urandom() & 32'hFFFF_FF80) | 32'(op));
        a_ireq = 0; a_iren = 0; a_dreq = 0; a_dwe = 0;
        a_rfwe = 0; a_pc = 0; a_trap = 0; a_halt = 0;
        for (int k = 0; k < len; k++) begin
          if (k > 0) cyc(1);
          a_ireq += int'(imemReq[1]);
          a_iren += int'(irEn[1]);
          a_dreq += int'(dmemReq[1]);
          a_dwe  += int'(dataWe[1]);
          a_rfwe += int'(regFileWe[1]);
          a_pc   += int'(pcEn[1]);
          a_trap += int'(trap[1]);
          a_halt += int'(halted[1]);
        end
        chk($sformatf("rand[%0d] c%0d rd%0d ad%0d", n, c, rd, ad),
            {a_ireq[3:0], a_iren[3:0], a_dreq[3:0], a_dwe[3:0],
             a_rfwe[3:0], a_pc[3:0], a_trap[3:0], 4'h0},
            {e_ireq[3:0], e_iren[3:0], e_dreq[3:0], e_dwe[3:0],
             e_rfwe[3:0], e_pc[3:0], e_trap[3:0], 4'h0});
        chk($sformatf("rand_cause[%0d]", n),
            32'({a_halt[7:0], cause[1]}),
            32'({8'd0, last_cause}));
        cyc(1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
